miss_replay_unit: RTL and testbench

Downstream consumer of the data cache's wait buffer. When a missed block returns from memory, the unit latches the block and triggers the wait buffer's walk for that block. It then consumes one parked entry per cycle, oldest first: loads are extracted from the block and written back, and stores are merged into the block. Finally it writes the merged block into the cache data array.

---
 rtl/miss_replay_unit.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_miss_replay_unit.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/miss_replay_unit.sv
`default_nettype none
// ============================================================================
// Module      : miss_replay_unit
// Description : Replays the cache misses that were parked in the wait buffer
//               once the missed block comes back from memory. The block is
//               latched, the wait-buffer walk is started for that block, and
//               one parked entry is consumed per cycle, oldest first. Loads
//               are extracted from the block and written back; stores are
//               merged into the block. The merged block is then written into
//               the cache data array.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   refill_valid/_ready   refill handshake (ready only while idle)
//   refill_address/_data  returned block address and contents
//   wb_search_invalidate  one-cycle pulse that starts the wait-buffer walk
//   wb_search_address     block address being searched (0 while idle)
//   wb_in_walk_mode       wait buffer is presenting walked entries
//   wb_found_one          at least one entry matches (sampled in SEARCH)
//   wb_found_multi        more entries follow the current one
//   wb_*                  fields of the entry currently walked
//   wrb_*                 registered load writeback, one cycle after entry
//   cache_wr_*            merged block write, one cycle after the walk
//
// Revision    : 1.0 - initial release
// ============================================================================
module miss_replay_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_BITS      = 32,
  parameter int BLOCK_WIDTH    = 256,
  parameter int BLOCK_ID_START = 5,
  parameter int R_WIDTH        = 6,
  parameter int MICROOP        = 5,
  parameter int ROB_TICKET     = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  // refill from memory
  input  logic                   refill_valid,
  output logic                   refill_ready,
  input  logic [ADDR_BITS-1:0]   refill_address,
  input  logic [BLOCK_WIDTH-1:0] refill_data,
  // wait-buffer search / walk
  output logic                   wb_search_invalidate,
  output logic [ADDR_BITS-1:0]   wb_search_address,
  input  logic                   wb_in_walk_mode,
  input  logic                   wb_found_one,
  input  logic                   wb_found_multi,
  input  logic                   wb_is_store,
  input  logic [ADDR_BITS-1:0]   wb_address,
  input  logic [DATA_WIDTH-1:0]  wb_data,
  input  logic [MICROOP-1:0]     wb_microop,
  input  logic [R_WIDTH-1:0]     wb_dest,
  input  logic [ROB_TICKET-1:0]  wb_ticket,
  // load writeback
  output logic                   wrb_valid,
  output logic [DATA_WIDTH-1:0]  wrb_data,
  output logic [R_WIDTH-1:0]     wrb_dest,
  output logic [ROB_TICKET-1:0]  wrb_ticket,
  // cache data-array write
  output logic                   cache_wr_valid,
  output logic [ADDR_BITS-1:0]   cache_wr_address,
  output logic [BLOCK_WIDTH-1:0] cache_wr_data,
  output logic                   cache_wr_dirty
);

  localparam int c_OFF = BLOCK_ID_START;      // byte-offset bits
  localparam int c_BB  = BLOCK_ID_START + 3;  // bit-position width inside block

  localparam logic [1:0] c_S_IDLE   = 2'd0;
  localparam logic [1:0] c_S_SEARCH = 2'd1;
  localparam logic [1:0] c_S_WALK   = 2'd2;
  localparam logic [1:0] c_S_WRITE  = 2'd3;

  localparam logic [MICROOP-1:0] c_LW  = MICROOP'(1);
  localparam logic [MICROOP-1:0] c_LH  = MICROOP'(2);
  localparam logic [MICROOP-1:0] c_LHU = MICROOP'(3);
  localparam logic [MICROOP-1:0] c_LB  = MICROOP'(4);
  localparam logic [MICROOP-1:0] c_LBU = MICROOP'(5);
  localparam logic [MICROOP-1:0] c_SW  = MICROOP'(6);
  localparam logic [MICROOP-1:0] c_SH  = MICROOP'(7);
  localparam logic [MICROOP-1:0] c_SB  = MICROOP'(8);

  localparam logic [BLOCK_WIDTH-1:0] c_MASK_W = {{(BLOCK_WIDTH-32){1'b0}}, 32'hFFFF_FFFF};
  localparam logic [BLOCK_WIDTH-1:0] c_MASK_H = {{(BLOCK_WIDTH-16){1'b0}}, 16'hFFFF};
  localparam logic [BLOCK_WIDTH-1:0] c_MASK_B = {{(BLOCK_WIDTH-8){1'b0}}, 8'hFF};

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  logic [1:0]             state_q, state_d;
  logic [BLOCK_WIDTH-1:0] blk_q, blk_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic                   dirty_q, dirty_d;
  logic                   wrb_valid_q, wrb_valid_d;
  logic [DATA_WIDTH-1:0]  wrb_data_q, wrb_data_d;
  logic [R_WIDTH-1:0]     wrb_dest_q, wrb_dest_d;
  logic [ROB_TICKET-1:0]  wrb_ticket_q, wrb_ticket_d;

  // Offset bits of the refill address, the upper bits of the walked address
  // (the wait buffer already matched the block) and wb_is_store (the microop
  // carries the same information) are intentionally not consumed.
  logic w_unused_bits;
  assign w_unused_bits = ^{wb_is_store, wb_address[ADDR_BITS-1:c_OFF],
                           refill_address[c_OFF-1:0]};

  logic w_accept;
  logic w_entry;
  assign w_accept = (state_q == c_S_IDLE) && refill_valid;
  assign w_entry  = (state_q == c_S_WALK) && wb_in_walk_mode;

  // --------------------------------------------------------------------------
  // Entry decode: extract load data / build store merge mask
  // --------------------------------------------------------------------------
  logic [c_OFF-1:0]       w_off;
  logic [c_BB-1:0]        w_word_base;
  logic [c_BB-1:0]        w_half_base;
  logic [c_BB-1:0]        w_byte_base;
  logic [DATA_WIDTH-1:0]  w_word;
  logic [15:0]            w_half;
  logic [7:0]             w_byte;
  logic [BLOCK_WIDTH-1:0] w_wdata_ext;

  assign w_off       = wb_address[c_OFF-1:0];
  // Offset bits below the access size are dropped to align the access.
  assign w_word_base = {w_off[c_OFF-1:2], 5'b00000};
  assign w_half_base = {w_off[c_OFF-1:1], 4'b0000};
  assign w_byte_base = {w_off, 3'b000};
  assign w_word      = blk_q[w_word_base +: DATA_WIDTH];
  assign w_half      = blk_q[w_half_base +: 16];
  assign w_byte      = blk_q[w_byte_base +: 8];
  assign w_wdata_ext = {{(BLOCK_WIDTH-DATA_WIDTH){1'b0}}, wb_data};

  logic                   w_is_load;
  logic [DATA_WIDTH-1:0]  w_load_data;
  logic                   w_is_store;
  logic [BLOCK_WIDTH-1:0] w_st_mask;
  logic [c_BB-1:0]        w_st_base;

  always_comb begin
    w_is_load   = 1'b0;
    w_load_data = '0;
    w_is_store  = 1'b0;
    w_st_mask   = '0;
    w_st_base   = '0;
    case (wb_microop)
      c_LW: begin
        w_is_load   = 1'b1;
        w_load_data = w_word;
      end
      c_LH: begin
        w_is_load   = 1'b1;
        w_load_data = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
      end
      c_LHU: begin
        w_is_load   = 1'b1;
        w_load_data = {{(DATA_WIDTH-16){1'b0}}, w_half};
      end
      c_LB: begin
        w_is_load   = 1'b1;
        w_load_data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
      end
      c_LBU: begin
        w_is_load   = 1'b1;
        w_load_data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
      end
      c_SW: begin
        w_is_store = 1'b1;
        w_st_mask  = c_MASK_W;
        w_st_base  = w_word_base;
      end
      c_SH: begin
        w_is_store = 1'b1;
        w_st_mask  = c_MASK_H;
        w_st_base  = w_half_base;
      end
      c_SB: begin
        w_is_store = 1'b1;
        w_st_mask  = c_MASK_B;
        w_st_base  = w_byte_base;
      end
      default: ;  // unknown microop: entry consumed with no effect
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath next-state
  // --------------------------------------------------------------------------
  always_comb begin
    blk_d        = blk_q;
    addr_d       = addr_q;
    dirty_d      = dirty_q;
    wrb_valid_d  = 1'b0;
    wrb_data_d   = wrb_data_q;
    wrb_dest_d   = wrb_dest_q;
    wrb_ticket_d = wrb_ticket_q;
    if (w_accept) begin
      blk_d   = refill_data;
      addr_d  = {refill_address[ADDR_BITS-1:c_OFF], {c_OFF{1'b0}}};
      dirty_d = 1'b0;
    end else if (w_entry) begin
      if (w_is_store) begin
        // Merged block is visible to the next walked entry, so younger loads
        // observe older stores to the same block.
        blk_d   = (blk_q & ~(w_st_mask << w_st_base)) |
                  ((w_wdata_ext & w_st_mask) << w_st_base);
        dirty_d = 1'b1;
      end
      if (w_is_load) begin
        wrb_valid_d  = 1'b1;
        wrb_data_d   = w_load_data;
        wrb_dest_d   = wb_dest;
        wrb_ticket_d = wb_ticket;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_q        <= '0;
      addr_q       <= '0;
      dirty_q      <= 1'b0;
      wrb_valid_q  <= 1'b0;
      wrb_data_q   <= '0;
      wrb_dest_q   <= '0;
      wrb_ticket_q <= '0;
    end else begin
      blk_q        <= blk_d;
      addr_q       <= addr_d;
      dirty_q      <= dirty_d;
      wrb_valid_q  <= wrb_valid_d;
      wrb_data_q   <= wrb_data_d;
      wrb_dest_q   <= wrb_dest_d;
      wrb_ticket_q <= wrb_ticket_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_S_IDLE: begin
        if (refill_valid) state_d = c_S_SEARCH;
      end
      c_S_SEARCH: begin
        state_d = wb_found_one ? c_S_WALK : c_S_WRITE;
      end
      c_S_WALK: begin
        // A dropped walk mode ends the walk just like the last entry does.
        if (!wb_in_walk_mode || !wb_found_multi) state_d = c_S_WRITE;
      end
      c_S_WRITE: begin
        state_d = c_S_IDLE;
      end
      default: state_d = c_S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    refill_ready         = 1'b0;
    wb_search_invalidate = 1'b0;
    wb_search_address    = addr_q;
    cache_wr_valid       = 1'b0;
    cache_wr_address     = '0;
    cache_wr_data        = '0;
    cache_wr_dirty       = 1'b0;
    case (state_q)
      c_S_IDLE: begin
        refill_ready      = 1'b1;
        wb_search_address = '0;
      end
      c_S_SEARCH: begin
        wb_search_invalidate = wb_found_one;
      end
      c_S_WRITE: begin
        cache_wr_valid   = 1'b1;
        cache_wr_address = addr_q;
        cache_wr_data    = blk_q;
        cache_wr_dirty   = dirty_q;
      end
      default: ;
    endcase
  end

  assign wrb_valid  = wrb_valid_q;
  assign wrb_data   = wrb_data_q;
  assign wrb_dest   = wrb_dest_q;
  assign wrb_ticket = wrb_ticket_q;

endmodule
`default_nettype wire

// File: tb/tb_miss_replay_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_miss_replay_unit
// Description : Self-checking bench for miss_replay_unit. The wait buffer is
//               modelled by the bench; expected results come from a byte-array
//               model of the refill block.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_miss_replay_unit;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         refill_valid;
  logic         refill_ready;
  logic [31:0]  refill_address;
  logic [255:0] refill_data;
  logic         wb_search_invalidate;
  logic [31:0]  wb_search_address;
  logic         wb_in_walk_mode;
  logic         wb_found_one;
  logic         wb_found_multi;
  logic         wb_is_store;
  logic [31:0]  wb_address;
  logic [31:0]  wb_data;
  logic [4:0]   wb_microop;
  logic [5:0]   wb_dest;
  logic [2:0]   wb_ticket;
  logic         wrb_valid;
  logic [31:0]  wrb_data;
  logic [5:0]   wrb_dest;
  logic [2:0]   wrb_ticket;
  logic         cache_wr_valid;
  logic [31:0]  cache_wr_address;
  logic [255:0] cache_wr_data;
  logic         cache_wr_dirty;

  always #5 clk = ~clk;

  miss_replay_unit dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .refill_valid         (refill_valid),
    .refill_ready         (refill_ready),
    .refill_address       (refill_address),
    .refill_data          (refill_data),
    .wb_search_invalidate (wb_search_invalidate),
    .wb_search_address    (wb_search_address),
    .wb_in_walk_mode      (wb_in_walk_mode),
    .wb_found_one         (wb_found_one),
    .wb_found_multi       (wb_found_multi),
    .wb_is_store          (wb_is_store),
    .wb_address           (wb_address),
    .wb_data              (wb_data),
    .wb_microop           (wb_microop),
    .wb_dest              (wb_dest),
    .wb_ticket            (wb_ticket),
    .wrb_valid            (wrb_valid),
    .wrb_data             (wrb_data),
    .wrb_dest             (wrb_dest),
    .wrb_ticket           (wrb_ticket),
    .cache_wr_valid       (cache_wr_valid),
    .cache_wr_address     (cache_wr_address),
    .cache_wr_data        (cache_wr_data),
    .cache_wr_dirty       (cache_wr_dirty)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [4:0]  uop;
    logic [31:0] addr;
    logic [31:0] data;
    logic [5:0]  dest;
    logic [2:0]  tkt;
  } entry_t;

  entry_t      ents[$];
  logic [7:0]  mb[32];    // reference block, byte 0 = bits [7:0]
  logic        mdirty;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add(input logic [4:0] uop, input logic [31:0] addr, input logic [31:0] data,
                     input logic [5:0] dest, input logic [2:0] tkt);
    entry_t e;
    e.uop = uop; e.addr = addr; e.data = data; e.dest = dest; e.tkt = tkt;
    ents.push_back(e);
  endtask

  function automatic logic [255:0] model_block();
    logic [255:0] b;
    for (int i = 0; i < 32; i++) b[8*i +: 8] = mb[i];
    return b;
  endfunction

  // Apply one walked entry to the model; report whether it is a load and its value.
  task automatic model_apply(input entry_t e, output logic ld, output logic [31:0] val);
    int  size;
    bit  sgn;
    bit  st;
    int  base;
    size = 0; sgn = 0; st = 0; ld = 1'b0; val = '0;
    case (e.uop)
      5'd1: size = 4;
      5'd2: begin size = 2; sgn = 1; end
      5'd3: size = 2;
      5'd4: begin size = 1; sgn = 1; end
      5'd5: size = 1;
      5'd6: begin size = 4; st = 1; end
      5'd7: begin size = 2; st = 1; end
      5'd8: begin size = 1; st = 1; end
      default: size = 0;
    endcase
    if (size != 0) begin
      base = int'(e.addr[4:0]);
      base = base - (base % size);
      if (st) begin
        for (int k = 0; k < size; k++) mb[base + k] = 8'(e.data >> (8 * k));
        mdirty = 1'b1;
      end else begin
        ld = 1'b1;
        for (int k = 0; k < size; k++) val = val | (32'(mb[base + k]) << (8 * k));
        if (sgn && val[8*size-1]) val = val | (32'hFFFF_FFFF << (8 * size));
      end
    end
  endtask

  task automatic idle_wb();
    wb_in_walk_mode = 1'b0; wb_found_one = 1'b0; wb_found_multi = 1'b0;
    wb_is_store = 1'b0; wb_address = '0; wb_data = '0; wb_microop = '0;
    wb_dest = '0; wb_ticket = '0;
  endtask

  // Full refill transaction walking the queued entries; starts right after a negedge.
  task automatic run_refill(input logic [31:0] addr, input logic [255:0] blk);
    int          n;
    logic        exp_v;
    logic [31:0] exp_d;
    logic [5:0]  exp_dest;
    logic [2:0]  exp_t;
    logic        ld;
    logic [31:0] val;
    logic [31:0] aaddr;
    n = ents.size();
    aaddr = {addr[31:5], 5'b0};
    for (int i = 0; i < 32; i++) mb[i] = blk[8*i +: 8];
    mdirty = 1'b0; exp_v = 1'b0; exp_d = '0; exp_dest = '0; exp_t = '0;

    @(posedge clk); #1;
    refill_valid = 1'b1; refill_address = addr; refill_data = blk;
    @(negedge clk);
    check("idle_ready", refill_ready, 1'b1);
    check("idle_search_addr", wb_search_address, 32'h0);

    @(posedge clk); #1;                               // SEARCH
    refill_valid = 1'b0; refill_data = $urandom;
    wb_found_one = (n > 0);
    @(negedge clk);
    check("search_inval", wb_search_invalidate, (n > 0));
    check("search_addr", wb_search_address, aaddr);
    check("search_ready", refill_ready, 1'b0);

    for (int i = 0; i < n; i++) begin                  // WALK, one entry per cycle
      @(posedge clk); #1;
      wb_in_walk_mode = 1'b1; wb_found_multi = (i < n - 1);
      wb_microop = ents[i].uop; wb_address = ents[i].addr; wb_data = ents[i].data;
      wb_dest = ents[i].dest; wb_ticket = ents[i].tkt;
      wb_is_store = (ents[i].uop >= 5'd6 && ents[i].uop <= 5'd8);
      @(negedge clk);
      check("walk_wrb_valid", wrb_valid, exp_v);
      if (exp_v) begin
        check("walk_wrb_data", wrb_data, exp_d);
        check("walk_wrb_dest", wrb_dest, exp_dest);
        check("walk_wrb_ticket", wrb_ticket, exp_t);
      end
      check("walk_cache_wr_valid", cache_wr_valid, 1'b0);
      check("walk_ready", refill_ready, 1'b0);
      model_apply(ents[i], ld, val);
      exp_v = ld; exp_d = val; exp_dest = ents[i].dest; exp_t = ents[i].tkt;
    end

    @(posedge clk); #1;                               // WRITE
    idle_wb();
    @(negedge clk);
    check("write_valid", cache_wr_valid, 1'b1);
    check("write_addr", cache_wr_address, aaddr);
    check("write_data", cache_wr_data, model_block());
    check("write_dirty", cache_wr_dirty, mdirty);
    check("write_wrb_valid", wrb_valid, exp_v);
    if (exp_v) begin
      check("write_wrb_data", wrb_data, exp_d);
      check("write_wrb_dest", wrb_dest, exp_dest);
      check("write_wrb_ticket", wrb_ticket, exp_t);
    end

    @(posedge clk); #1;                               // back in IDLE
    @(negedge clk);
    check("post_cache_wr_valid", cache_wr_valid, 1'b0);
    check("post_wrb_valid", wrb_valid, 1'b0);
    check("post_ready", refill_ready, 1'b1);
    ents.delete();
  endtask

  function automatic logic [255:0] rand_block();
    logic [255:0] b;
    for (int i = 0; i < 8; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  logic [255:0] blk0;
  logic [31:0]  raddr;
  logic [4:0]   uop;
  int           n;

  initial begin
    rst_n = 1'b0;
    refill_valid = 1'b0; refill_address = '0; refill_data = '0;
    idle_wb();

    // Reset state
    @(negedge clk);
    check("rst_ready", refill_ready, 1'b1);
    check("rst_inval", wb_search_invalidate, 1'b0);
    check("rst_search_addr", wb_search_address, 32'h0);
    check("rst_wrb_valid", wrb_valid, 1'b0);
    check("rst_wrb_data", wrb_data, 32'h0);
    check("rst_cache_valid", cache_wr_valid, 1'b0);
    check("rst_cache_data", cache_wr_data, 256'h0);
    check("rst_cache_dirty", cache_wr_dirty, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);

    blk0 = rand_block();
    blk0[64 +: 32] = 32'h8000_ABCD;

    // Empty walk
    run_refill(32'h0000_0100, blk0);
    // Single LW
    add(5'd1, 32'h108, $urandom, 6'd5, 3'd3);
    run_refill(32'h0000_0100, blk0);
    // Sign/zero extension
    add(5'd2, 32'h10A, $urandom, 6'd1, 3'd1);
    add(5'd3, 32'h10A, $urandom, 6'd2, 3'd2);
    add(5'd4, 32'h108, $urandom, 6'd3, 3'd4);
    run_refill(32'h0000_0100, blk0);
    // Store-to-load forwarding within one walk
    add(5'd8, 32'h109, 32'h1234_565A, 6'd7, 3'd0);
    add(5'd1, 32'h108, $urandom, 6'd8, 3'd5);
    run_refill(32'h0000_0100, blk0);
    // Four entries, mixed; offset bits on refill address ignored
    add(5'd6, 32'h110, 32'hDEAD_BEEF, 6'd9, 3'd1);
    add(5'd1, 32'h112, $urandom, 6'd10, 3'd2);
    add(5'd7, 32'h11E, 32'h0000_C0DE, 6'd11, 3'd3);
    add(5'd5, 32'h11F, $urandom, 6'd12, 3'd4);
    run_refill(32'h0000_0117, blk0);

    // Random transactions including unknown microops
    for (int t = 0; t < 40; t++) begin
      raddr = $urandom;
      n = $urandom_range(0, 7);
      for (int i = 0; i < n; i++) begin
        uop = 5'($urandom_range(0, 10));
        if ($urandom_range(0, 9) == 0) uop = 5'd31;
        add(uop, {raddr[31:5], 5'($urandom)}, $urandom, 6'($urandom), 3'($urandom));
      end
      run_refill(raddr, rand_block());
    end

    // Reset during WALK
    @(posedge clk); #1;
    refill_valid = 1'b1; refill_address = 32'h0000_2000; refill_data = rand_block();
    @(posedge clk); #1;
    refill_valid = 1'b0; wb_found_one = 1'b1;
    @(posedge clk); #1;
    wb_in_walk_mode = 1'b1; wb_found_multi = 1'b1;
    wb_microop = 5'd1; wb_address = 32'h2004; wb_dest = 6'd3; wb_ticket = 3'd6;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ready", refill_ready, 1'b1);
    check("midrst_wrb_valid", wrb_valid, 1'b0);
    check("midrst_wrb_data", wrb_data, 32'h0);
    check("midrst_search_addr", wb_search_address, 32'h0);
    check("midrst_inval", wb_search_invalidate, 1'b0);
    check("midrst_cache_valid", cache_wr_valid, 1'b0);
    idle_wb();
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_after_cache_valid", cache_wr_valid, 1'b0);
      check("midrst_after_wrb_valid", wrb_valid, 1'b0);
      check("midrst_after_ready", refill_ready, 1'b1);
    end

    // Recovery after reset
    add(5'd6, 32'h3000, 32'hCAFE_F00D, 6'd1, 3'd1);
    add(5'd4, 32'h3003, $urandom, 6'd2, 3'd2);
    run_refill(32'h0000_3000, rand_block());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
